// File: rtl/mem_dump_reader.sv
// Memory dump initiator: reads a word range over an async-read port and streams it out as bytes, LSB first.
// Optional trailing XOR checksum byte is enabled with `define MEM_DUMP_CHECKSUM_EN.
module mem_dump_reader #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDRESS = 5,
    parameter int NB_BYTE    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [NB_ADDRESS-1:0] i_base_addr,
    input  logic [NB_ADDRESS:0]   i_num_words,
    output logic [NB_ADDRESS-1:0] o_r_addr,
    output logic                  o_r_en,
    input  logic [NB_DATA-1:0]    i_r_data,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2:0]            o_dbg_state
);

    localparam int NB_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_SEND = 3'd2,
        ST_DONE = 3'd3
`ifdef MEM_DUMP_CHECKSUM_EN
        ,
        ST_CSUM = 3'd4
`endif
    } state_t;

    // State entered once the last data byte has gone (or immediately for an empty dump).
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam state_t ST_END = ST_CSUM;
`else
    localparam state_t ST_END = ST_DONE;
`endif

    state_t                r_state;
    state_t                w_next_state;
    logic [NB_ADDRESS-1:0] r_addr;
    logic [NB_ADDRESS:0]   r_words;
    logic [NB_DATA-1:0]    r_word;
    logic [NB_IDX-1:0]     r_idx;
    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_last_byte;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0]    r_csum;
`endif

    assign w_accept    = (r_state == ST_IDLE) && i_start;
    assign w_xfer      = o_tx_valid && i_tx_ready;
    assign w_last_byte = (r_idx == NB_IDX'(NB_BYTES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = (i_num_words == '0) ? ST_END : ST_READ;
                end
            end
            ST_READ: w_next_state = ST_SEND;
            ST_SEND: begin
                if (w_xfer && w_last_byte) begin
                    w_next_state = (r_words == (NB_ADDRESS+1)'(1)) ? ST_END : ST_READ;
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (w_xfer) begin
                    w_next_state = ST_DONE;
                end
            end
`endif
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_r_en      = 1'b0;
        o_tx_valid  = 1'b0;
        o_tx_data   = '0;
        o_done      = 1'b0;
        o_busy      = (r_state != ST_IDLE);
        o_r_addr    = r_addr;
        o_dbg_state = r_state;
        case (r_state)
            ST_READ: o_r_en = 1'b1;
            ST_SEND: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_word[NB_BYTE-1:0];
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_csum;
            end
`endif
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    // The captured word shifts right on each transfer so the current byte always sits in the low lane.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_words <= '0;
            r_word  <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_addr  <= i_base_addr;
            r_words <= i_num_words;
        end else if (r_state == ST_READ) begin
            r_word <= i_r_data;
            r_idx  <= '0;
        end else if ((r_state == ST_SEND) && w_xfer) begin
            r_word <= r_word >> NB_BYTE;
            if (w_last_byte) begin
                r_idx   <= '0;
                r_words <= r_words - 1'b1;
                r_addr  <= r_addr + 1'b1;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= '0;
        end else if ((r_state == ST_SEND) && w_xfer) begin
            r_csum <= r_csum ^ r_word[NB_BYTE-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: scenario tasks compare the byte/address stream against a word-level reference.
module tb_mem_dump_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  base_addr;
    logic [5:0]  num_words;
    logic [4:0]  r_addr;
    logic        r_en;
    logic [31:0] r_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    logic [31:0] mem [0:31];
    assign r_data = mem[r_addr];

    mem_dump_reader dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_num_words (num_words),
        .o_r_addr    (r_addr),
        .o_r_en      (r_en),
        .i_r_data    (r_data),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_b[$];
    logic [7:0] exp_a[$];
    logic [7:0] obs_b[$];
    logic [7:0] obs_a[$];
    int         exp_done;
    int         done_cyc;
    int         stable_err;
    bit         timed_out;
    logic       busy_first;
    logic       busy_at_done;

`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int CSUM_EXTRA = 1;
`else
    localparam int CSUM_EXTRA = 0;
`endif

    // Reference: the dump is a list of word addresses, each word unpacked LSB first.
    task automatic model(input int base, input int num);
        logic [7:0]  csum;
        logic [31:0] word;
        int          a;
        exp_b.delete();
        exp_a.delete();
        csum = 8'h00;
        for (int w = 0; w < num; w++) begin
            a = (base + w) % 32;
            exp_a.push_back(8'(a));
            word = mem[a];
            for (int k = 0; k < 4; k++) begin
                exp_b.push_back(word[8*k +: 8]);
                csum = csum ^ word[8*k +: 8];
            end
        end
        if (CSUM_EXTRA != 0) exp_b.push_back(csum);
        exp_done = 1 + num * 5 + CSUM_EXTRA;
    endtask

    function automatic int first_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
        foreach (a[i]) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic drive_start(input int base, input int num);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 5'(base);
        num_words = 6'(num);
        tx_ready  = 1'b1;
    endtask

    // Records the stream cycle by cycle until o_done; cycle 1 is the cycle after the start cycle.
    task automatic capture(input int budget, input int mode, input int inj_cyc);
        logic       hold;
        logic [7:0] hold_d;
        obs_b.delete();
        obs_a.delete();
        done_cyc   = -1;
        stable_err = 0;
        timed_out  = 1'b1;
        hold       = 1'b0;
        hold_d     = 8'h00;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = (c == inj_cyc);
            if (c == inj_cyc) begin
                base_addr = 5'd20;
                num_words = 6'd1;
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (c == 1) busy_first = busy;
            if (hold && (!tx_valid || tx_data !== hold_d)) stable_err++;
            hold   = tx_valid && !tx_ready;
            hold_d = tx_data;
            if (r_en) obs_a.push_back({3'b000, r_addr});
            if (tx_valid && tx_ready) obs_b.push_back(tx_data);
            if (done) begin
                done_cyc     = c;
                busy_at_done = busy;
                timed_out    = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 32; i++) mem[i] = 32'h8000_0001 | $urandom;
        rst_n     = 1'b0;
        start     = 1'b1;
        base_addr = 5'd3;
        num_words = 6'd2;
        tx_ready  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({r_addr, r_en, tx_data, tx_valid, busy, done} !== 17'd0)
                $display("FAIL reset_outputs cycle %0d got addr=%0d en=%b data=%h valid=%b busy=%b done=%b want all 0",
                         c, r_addr, r_en, tx_data, tx_valid, busy, done);
            else n_pass++;
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || r_en !== 1'b0) $display("FAIL reset_idle got busy=%b en=%b want 0 0", busy, r_en);
        else n_pass++;
    endtask

    task automatic test_basic;
        int d;
        mem[2] = 32'h1122_3344;
        mem[3] = 32'hAABB_CCDD;
        model(2, 2);
        drive_start(2, 2);
        capture(60, 0, 0);
        n_checks++;
        if (timed_out) $display("FAIL basic_timeout got no o_done within 60 cycles want o_done");
        else n_pass++;
        d = first_diff(obs_b, exp_b);
        n_checks++;
        if (d >= 0) $display("FAIL basic_bytes at %0d got n=%0d want n=%0d", d, obs_b.size(), exp_b.size());
        else n_pass++;
        n_checks++;
        if (obs_b.size() < 1 || obs_b[0] !== 8'h44) $display("FAIL basic_first_byte got size %0d want 44", obs_b.size());
        else n_pass++;
        d = first_diff(obs_a, exp_a);
        n_checks++;
        if (d >= 0) $display("FAIL basic_addrs at %0d got n=%0d want n=%0d", d, obs_a.size(), exp_a.size());
        else n_pass++;
        n_checks++;
        if (done_cyc != exp_done) $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, exp_done);
        else n_pass++;
        n_checks++;
        if (busy_first !== 1'b1 || busy_at_done !== 1'b1)
            $display("FAIL basic_busy got first=%b at_done=%b want 1 1", busy_first, busy_at_done);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL basic_after got busy=%b done=%b want 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int d;
        model(2, 2);
        drive_start(2, 2);
        capture(120, 1, 0);
        d = first_diff(obs_b, exp_b);
        n_checks++;
        if (timed_out || d >= 0)
            $display("FAIL bp_bytes at %0d got n=%0d timeout=%b want n=%0d", d, obs_b.size(), timed_out, exp_b.size());
        else n_pass++;
        n_checks++;
        if (stable_err != 0) $display("FAIL bp_stable got %0d unstable stall cycles want 0", stable_err);
        else n_pass++;
    endtask

    task automatic test_wrap_zero;
        int d;
        model(31, 2);
        drive_start(31, 2);
        capture(60, 0, 0);
        d = first_diff(obs_a, exp_a);
        n_checks++;
        if (d >= 0 || obs_a.size() != 2) $display("FAIL wrap_addrs at %0d got n=%0d want 31,0", d, obs_a.size());
        else n_pass++;
        d = first_diff(obs_b, exp_b);
        n_checks++;
        if (timed_out || d >= 0) $display("FAIL wrap_bytes at %0d got n=%0d want n=%0d", d, obs_b.size(), exp_b.size());
        else n_pass++;
        model(9, 0);
        drive_start(9, 0);
        capture(20, 0, 0);
        n_checks++;
        if (done_cyc != exp_done) $display("FAIL zero_done_cycle got %0d want %0d", done_cyc, exp_done);
        else n_pass++;
        n_checks++;
        if (obs_b.size() != exp_b.size() || obs_a.size() != 0)
            $display("FAIL zero_stream got bytes=%0d reads=%0d want bytes=%0d reads=0", obs_b.size(), obs_a.size(), exp_b.size());
        else n_pass++;
    endtask

    task automatic test_start_while_busy;
        int d;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        model(7, 2);
        drive_start(7, 2);
        capture(60, 0, 4);
        d = first_diff(obs_b, exp_b);
        n_checks++;
        if (timed_out || d >= 0) $display("FAIL busy_start_bytes at %0d got n=%0d want n=%0d", d, obs_b.size(), exp_b.size());
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_start_idle got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int         d;
        int         seen;
        logic [7:0] got[$];
        logic       saw_done;
        model(5, 3);
        drive_start(5, 3);
        seen = 0;
        for (int c = 1; c <= 20 && seen < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                seen++;
            end
        end
        n_checks++;
        if (seen != 3 || got[0] !== exp_b[0] || got[2] !== exp_b[2])
            $display("FAIL mid_prefix got %0d bytes want first 3 of model", seen);
        else n_pass++;
        @(negedge clk);
        rst_n    = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        n_checks++;
        if ({r_addr, r_en, tx_data, tx_valid, busy} !== 16'd0 || saw_done)
            $display("FAIL mid_reset got addr=%0d en=%b valid=%b busy=%b done_seen=%b want 0", r_addr, r_en, tx_valid, busy, saw_done);
        else n_pass++;
        rst_n = 1'b1;
        model(12, 1);
        drive_start(12, 1);
        capture(40, 0, 0);
        d = first_diff(obs_b, exp_b);
        n_checks++;
        if (timed_out || d >= 0 || done_cyc != exp_done)
            $display("FAIL mid_restart at %0d got n=%0d done=%0d want n=%0d done=%0d", d, obs_b.size(), done_cyc, exp_b.size(), exp_done);
        else n_pass++;
    endtask

    task automatic test_random;
        int d, base, num, mode;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            base = $urandom_range(0, 31);
            num  = $urandom_range(0, 4);
            mode = $urandom_range(0, 2);
            model(base, num);
            drive_start(base, num);
            capture(300, mode, 0);
            d = first_diff(obs_b, exp_b);
            n_checks++;
            if (timed_out || d >= 0)
                $display("FAIL rand_bytes it=%0d at %0d got n=%0d want n=%0d", it, d, obs_b.size(), exp_b.size());
            else n_pass++;
            d = first_diff(obs_a, exp_a);
            n_checks++;
            if (d >= 0 || stable_err != 0)
                $display("FAIL rand_addrs it=%0d at %0d got n=%0d unstable=%0d want n=%0d unstable=0", it, d, obs_a.size(), stable_err, exp_a.size());
            else n_pass++;
            if (mode == 0) begin
                n_checks++;
                if (done_cyc != exp_done) $display("FAIL rand_done it=%0d got %0d want %0d", it, done_cyc, exp_done);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        tx_ready  = 1'b0;
        test_reset;
        test_basic;
        test_backpressure;
        test_wrap_zero;
        test_start_while_busy;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
